// File: rtl/mrd_ctrl_pkg.sv
// Shared types, state encoding and supported-size table for the mixed-radix DFT frame sequencer.
package mrd_ctrl_pkg;

   localparam int MAX_STAGES = 6;
   localparam int NUM_SIZES  = 2;

   typedef logic [MAX_STAGES-1:0][2:0] nf_vec_t;
   typedef logic [2:0][9:0]            pfa_vec_t;

   // Upper two bits are the state code the memory sees; bit 0 splits ARM from RUN.
   typedef enum logic [2:0] {
      SINK_IDLE = 3'b000,
      SINK_RUN  = 3'b001,
      RD_ARM    = 3'b010,
      RD_RUN    = 3'b011,
      WR_ARM    = 3'b100,
      WR_RUN    = 3'b101,
      SRC_ARM   = 3'b110,
      SRC_RUN   = 3'b111
   } mrd_state_e;

   typedef struct packed {
      logic [2:0] num_stages;
      nf_vec_t    Nf;
      pfa_vec_t   Nf_PFA;
      logic [9:0] q_p;
      logic [9:0] r_p;
      logic [9:0] q_p_o;
      logic [9:0] r_p_o;
      logic       valid;
   } mrd_cfg_t;

   typedef struct packed {
      logic [11:0] size;
      mrd_cfg_t    cfg;
   } mrd_cfg_entry_t;

   localparam mrd_cfg_t CFG_NONE = '{num_stages: 3'd1, Nf: {MAX_STAGES{3'd1}}, Nf_PFA: '0,
                                     q_p: '0, r_p: '0, q_p_o: '0, r_p_o: '0, valid: 1'b0};

   // Packed vectors list the highest index first; q = N/N1, r = q mod N1 (output map uses N2).
   localparam mrd_cfg_entry_t CFG_TABLE [NUM_SIZES] = '{
      '{size: 12'd1200,
        cfg: '{num_stages: 3'd5,
               Nf: {3'd1, 3'd3, 3'd5, 3'd5, 3'd4, 3'd4},
               Nf_PFA: {10'd3, 10'd25, 10'd16},
               q_p: 10'd75, r_p: 10'd11, q_p_o: 10'd48, r_p_o: 10'd23,
               valid: 1'b1}},
      '{size: 12'd60,
        cfg: '{num_stages: 3'd3,
               Nf: {3'd1, 3'd1, 3'd1, 3'd3, 3'd5, 3'd4},
               Nf_PFA: {10'd3, 10'd5, 10'd4},
               q_p: 10'd15, r_p: 10'd3, q_p_o: 10'd12, r_p_o: 10'd2,
               valid: 1'b1}}
   };

   function automatic logic is_arm(input mrd_state_e s);
      return (s[0] == 1'b0) && (s != SINK_IDLE);
   endfunction

endpackage

// File: rtl/mrd_ctrl_seq_if.sv
// Control/status bundle between the frame sequencer (master) and the DFT memory top (slave).
interface mrd_ctrl_seq_if;
   import mrd_ctrl_pkg::*;

   logic        sink_sop;
   logic [11:0] sink_dftpts;
   logic        sink_ongoing;
   logic        rd_ongoing;
   logic        wr_ongoing;
   logic        source_ongoing;

   logic [1:0]  state;
   logic [2:0]  current_stage;
   logic [11:0] dftpts;
   nf_vec_t     Nf;
   pfa_vec_t    Nf_PFA;
   logic [9:0]  q_p;
   logic [9:0]  r_p;
   logic [9:0]  q_p_o;
   logic [9:0]  r_p_o;
   logic        frame_done;
   logic        err_timeout;
   logic        err_cfg;
   logic        drop_sop;

   modport master (
      input  sink_sop, sink_dftpts, sink_ongoing, rd_ongoing, wr_ongoing, source_ongoing,
      output state, current_stage, dftpts, Nf, Nf_PFA, q_p, r_p, q_p_o, r_p_o,
             frame_done, err_timeout, err_cfg, drop_sop
   );

   modport slave (
      output sink_sop, sink_dftpts, sink_ongoing, rd_ongoing, wr_ongoing, source_ongoing,
      input  state, current_stage, dftpts, Nf, Nf_PFA, q_p, r_p, q_p_o, r_p_o,
             frame_done, err_timeout, err_cfg, drop_sop
   );

endinterface

// File: rtl/mrd_cfg_lut.sv
// Combinational DFT size to factorisation lookup; unknown sizes return valid = 0.
module mrd_cfg_lut
   import mrd_ctrl_pkg::*;
(
   input  logic [11:0] i_dftpts,
   output mrd_cfg_t    o_cfg
);

   always_comb begin
      o_cfg = CFG_NONE;
      for (int i = 0; i < NUM_SIZES; i++) begin
         if (CFG_TABLE[i].size == i_dftpts) o_cfg = CFG_TABLE[i].cfg;
      end
   end

endmodule

// File: rtl/mrd_ctrl_seq.sv
// Frame sequencer: walks the memory through sink, read/write per stage and source,
// advancing on registered status edges, with an ARM-state watchdog.
module mrd_ctrl_seq
   import mrd_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 4095,
   parameter int W_CNT   = 12
) (
   input logic            clk,
   input logic            rst_n,
   mrd_ctrl_seq_if.master bus
);

   mrd_state_e       r_fsm, w_fsm_nxt;
   logic [2:0]       r_stage, w_stage_nxt;
   logic [W_CNT-1:0] r_wdog;
   logic             w_wdog_exp;

   logic r_sink_q, r_rd_q, r_wr_q, r_src_q;
   logic r_sink_fall, r_rd_rise, r_rd_fall, r_wr_rise, r_wr_fall, r_src_rise, r_src_fall;

   mrd_cfg_t    w_lut_cfg;
   logic        w_load_cfg;
   logic [11:0] r_dftpts;
   logic [2:0]  r_num_stages;
   nf_vec_t     r_nf;
   pfa_vec_t    r_nf_pfa;
   logic [9:0]  r_q_p, r_r_p, r_q_p_o, r_r_p_o;

   logic r_frame_done, r_err_timeout, r_err_cfg, r_drop_sop;
   logic w_frame_done, w_err_timeout, w_err_cfg, w_drop_sop;

   mrd_cfg_lut u_cfg_lut (
      .i_dftpts (bus.sink_dftpts),
      .o_cfg    (w_lut_cfg)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sink_q    <= 1'b0;
         r_rd_q      <= 1'b0;
         r_wr_q      <= 1'b0;
         r_src_q     <= 1'b0;
         r_sink_fall <= 1'b0;
         r_rd_rise   <= 1'b0;
         r_rd_fall   <= 1'b0;
         r_wr_rise   <= 1'b0;
         r_wr_fall   <= 1'b0;
         r_src_rise  <= 1'b0;
         r_src_fall  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every edge flop compares against last cycle's sample.
         r_sink_q    <= bus.sink_ongoing;
         r_rd_q      <= bus.rd_ongoing;
         r_wr_q      <= bus.wr_ongoing;
         r_src_q     <= bus.source_ongoing;
         r_sink_fall <= r_sink_q & ~bus.sink_ongoing;
         r_rd_rise   <= ~r_rd_q & bus.rd_ongoing;
         r_rd_fall   <= r_rd_q & ~bus.rd_ongoing;
         r_wr_rise   <= ~r_wr_q & bus.wr_ongoing;
         r_wr_fall   <= r_wr_q & ~bus.wr_ongoing;
         r_src_rise  <= ~r_src_q & bus.source_ongoing;
         r_src_fall  <= r_src_q & ~bus.source_ongoing;
      end
   end

   assign w_wdog_exp = (r_wdog == W_CNT'(TIMEOUT - 1));

   always_comb begin
      // NOTE: defaults first keep every branch fully assigned, so no latches are inferred.
      w_fsm_nxt     = r_fsm;
      w_stage_nxt   = r_stage;
      w_load_cfg    = 1'b0;
      w_frame_done  = 1'b0;
      w_err_timeout = 1'b0;
      w_err_cfg     = 1'b0;
      w_drop_sop    = bus.sink_sop && (r_fsm != SINK_IDLE);

      case (r_fsm)
         SINK_IDLE: begin
            if (bus.sink_sop) begin
               if (w_lut_cfg.valid) begin
                  w_load_cfg = 1'b1;
                  w_fsm_nxt  = SINK_RUN;
               end else begin
                  w_err_cfg = 1'b1;
               end
            end
         end
         SINK_RUN: if (r_sink_fall) begin
            w_stage_nxt = 3'd0;
            w_fsm_nxt   = RD_ARM;
         end
         RD_ARM:   if (r_rd_rise)  w_fsm_nxt = RD_RUN;
         RD_RUN:   if (r_rd_fall)  w_fsm_nxt = WR_ARM;
         WR_ARM:   if (r_wr_rise)  w_fsm_nxt = WR_RUN;
         WR_RUN: if (r_wr_fall) begin
            if (r_stage == r_num_stages - 3'd1) begin
               w_fsm_nxt = SRC_ARM;
            end else begin
               w_stage_nxt = r_stage + 3'd1;
               w_fsm_nxt   = RD_ARM;
            end
         end
         SRC_ARM:  if (r_src_rise) w_fsm_nxt = SRC_RUN;
         SRC_RUN: if (r_src_fall) begin
            w_frame_done = 1'b1;
            w_stage_nxt  = 3'd0;
            w_fsm_nxt    = SINK_IDLE;
         end
         default:  w_fsm_nxt = SINK_IDLE;
      endcase

      // A rising edge in the expiry cycle has already moved the FSM, so it wins.
      if (is_arm(r_fsm) && w_wdog_exp && (w_fsm_nxt == r_fsm)) begin
         w_err_timeout = 1'b1;
         w_stage_nxt   = 3'd0;
         w_fsm_nxt     = SINK_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_fsm         <= SINK_IDLE;
         r_stage       <= 3'd0;
         r_wdog        <= '0;
         r_dftpts      <= 12'd0;
         r_num_stages  <= CFG_NONE.num_stages;
         r_nf          <= CFG_NONE.Nf;
         r_nf_pfa      <= CFG_NONE.Nf_PFA;
         r_q_p         <= CFG_NONE.q_p;
         r_r_p         <= CFG_NONE.r_p;
         r_q_p_o       <= CFG_NONE.q_p_o;
         r_r_p_o       <= CFG_NONE.r_p_o;
         r_frame_done  <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_cfg     <= 1'b0;
         r_drop_sop    <= 1'b0;
      end else begin
         r_fsm         <= w_fsm_nxt;
         r_stage       <= w_stage_nxt;
         r_frame_done  <= w_frame_done;
         r_err_timeout <= w_err_timeout;
         r_err_cfg     <= w_err_cfg;
         r_drop_sop    <= w_drop_sop;

         if (w_fsm_nxt != r_fsm)  r_wdog <= '0;
         else if (is_arm(r_fsm))  r_wdog <= r_wdog + W_CNT'(1);

         if (w_load_cfg) begin
            r_dftpts     <= bus.sink_dftpts;
            r_num_stages <= w_lut_cfg.num_stages;
            r_nf         <= w_lut_cfg.Nf;
            r_nf_pfa     <= w_lut_cfg.Nf_PFA;
            r_q_p        <= w_lut_cfg.q_p;
            r_r_p        <= w_lut_cfg.r_p;
            r_q_p_o      <= w_lut_cfg.q_p_o;
            r_r_p_o      <= w_lut_cfg.r_p_o;
         end
      end
   end

   assign bus.state         = r_fsm[2:1];
   assign bus.current_stage = r_stage;
   assign bus.dftpts        = r_dftpts;
   assign bus.Nf            = r_nf;
   assign bus.Nf_PFA        = r_nf_pfa;
   assign bus.q_p           = r_q_p;
   assign bus.r_p           = r_r_p;
   assign bus.q_p_o         = r_q_p_o;
   assign bus.r_p_o         = r_r_p_o;
   assign bus.frame_done    = r_frame_done;
   assign bus.err_timeout   = r_err_timeout;
   assign bus.err_cfg       = r_err_cfg;
   assign bus.drop_sop      = r_drop_sop;

endmodule

// File: tb/tb_mrd_ctrl_seq.sv
// Directed bench for mrd_ctrl_seq: a small memory model answers each phase with status handshakes.
module tb_mrd_ctrl_seq;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done = 0;
   int   n_drop = 0;
   int   n_cfg  = 0;
   int   n_tmo  = 0;

   mrd_ctrl_seq_if bus ();

   mrd_ctrl_seq #(.TIMEOUT(4095), .W_CNT(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.frame_done  === 1'b1) n_done++;
      if (bus.drop_sop    === 1'b1) n_drop++;
      if (bus.err_cfg     === 1'b1) n_cfg++;
      if (bus.err_timeout === 1'b1) n_tmo++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ongoing(input int ph, input logic v);
      case (ph)
         1:       bus.rd_ongoing     = v;
         2:       bus.wr_ongoing     = v;
         default: bus.source_ongoing = v;
      endcase
   endtask

   task automatic wait_state(input logic [1:0] st, input string what);
      int n = 0;
      while (bus.state !== st && n < 50) begin
         tick();
         n++;
      end
      n_checks++;
      if (bus.state !== st) begin
         n_errors++;
         $display("FAIL %s: state %b, required %b within 50 cycles", what, bus.state, st);
      end
   endtask

   // Memory model for one read/write/source phase; returns in the cycle the next state shows.
   task automatic do_phase(input int ph, input logic [2:0] stg,
                           input logic [1:0] nxt_st, input logic [2:0] nxt_stg);
      logic [1:0] code;
      code = 2'(ph);
      wait_state(code, "phase_entry");
      n_checks++;
      if (bus.current_stage !== stg) begin
         n_errors++;
         $display("FAIL stage_at_entry: got %0d required %0d", bus.current_stage, stg);
      end
      tick();
      set_ongoing(ph, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus.state !== code || bus.current_stage !== stg) begin
            n_errors++;
            $display("FAIL phase_hold: state %b stage %0d required %b stage %0d",
                     bus.state, bus.current_stage, code, stg);
         end
      end
      set_ongoing(ph, 1'b0);
      tick();
      n_checks++;
      if (bus.state !== code) begin
         n_errors++;
         $display("FAIL fall_latency_early: state %b required %b", bus.state, code);
      end
      tick();
      n_checks++;
      if (bus.state !== nxt_st || bus.current_stage !== nxt_stg) begin
         n_errors++;
         $display("FAIL phase_exit: state %b stage %0d required %b stage %0d",
                  bus.state, bus.current_stage, nxt_st, nxt_stg);
      end
   endtask

   // Sop plus sink phase; returns in the first cycle of state 01.
   task automatic start_frame(input logic [11:0] size);
      bus.sink_sop     = 1'b1;
      bus.sink_dftpts  = size;
      bus.sink_ongoing = 1'b1;
      tick();
      bus.sink_sop = 1'b0;
      n_checks++;
      if (bus.dftpts !== size || bus.state !== 2'b00 || bus.drop_sop !== 1'b0) begin
         n_errors++;
         $display("FAIL sop_latch: dftpts %0d state %b drop %b required %0d 00 0",
                  bus.dftpts, bus.state, bus.drop_sop, size);
      end
      tick();
      tick();
      bus.sink_ongoing = 1'b0;
      tick();
      n_checks++;
      if (bus.state !== 2'b00) begin
         n_errors++;
         $display("FAIL sink_fall_early: state %b required 00", bus.state);
      end
      tick();
      n_checks++;
      if (bus.state !== 2'b01 || bus.current_stage !== 3'd0) begin
         n_errors++;
         $display("FAIL sink_exit: state %b stage %0d required 01 stage 0", bus.state, bus.current_stage);
      end
   endtask

   // Read/write from stage 'first' onward, then source; returns in the frame_done cycle.
   task automatic run_stages(input int first, input int n);
      for (int s = first; s < n; s++) begin
         do_phase(1, 3'(s), 2'b10, 3'(s));
         if (s == n - 1) do_phase(2, 3'(s), 2'b11, 3'(s));
         else            do_phase(2, 3'(s), 2'b01, 3'(s + 1));
      end
      do_phase(3, 3'(n - 1), 2'b00, 3'd0);
      n_checks++;
      if (bus.frame_done !== 1'b1) begin
         n_errors++;
         $display("FAIL frame_done: got %b required 1", bus.frame_done);
      end
   endtask

   task automatic test_reset();
      bus.sink_sop = 1'b0; bus.sink_dftpts = 12'd0; bus.sink_ongoing = 1'b0;
      bus.rd_ongoing = 1'b0; bus.wr_ongoing = 1'b0; bus.source_ongoing = 1'b0;
      rst_n = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (bus.state !== 2'b00 || bus.current_stage !== 3'd0 || bus.dftpts !== 12'd0) begin
         n_errors++;
         $display("FAIL reset_ctrl: state %b stage %0d dftpts %0d required 00 0 0",
                  bus.state, bus.current_stage, bus.dftpts);
      end
      n_checks++;
      if (bus.Nf !== 18'o111111 || bus.Nf_PFA !== 30'd0 || bus.q_p !== 10'd0 || bus.r_p !== 10'd0 ||
          bus.q_p_o !== 10'd0 || bus.r_p_o !== 10'd0) begin
         n_errors++;
         $display("FAIL reset_cfg: Nf %o Nf_PFA %h q_p %0d r_p %0d q_p_o %0d r_p_o %0d required 111111 0 0 0 0 0",
                  bus.Nf, bus.Nf_PFA, bus.q_p, bus.r_p, bus.q_p_o, bus.r_p_o);
      end
      n_checks++;
      if ({bus.frame_done, bus.err_timeout, bus.err_cfg, bus.drop_sop} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_pulses: got %b required 0000",
                  {bus.frame_done, bus.err_timeout, bus.err_cfg, bus.drop_sop});
      end
   endtask

   task automatic test_frame_1200();
      logic [5:0][2:0] nf_exp;
      logic [2:0][9:0] pfa_exp;
      int              d0;
      d0 = n_done;
      nf_exp[0] = 3'd4; nf_exp[1] = 3'd4; nf_exp[2] = 3'd5;
      nf_exp[3] = 3'd5; nf_exp[4] = 3'd3; nf_exp[5] = 3'd1;
      pfa_exp[0] = 10'd16; pfa_exp[1] = 10'd25; pfa_exp[2] = 10'd3;
      start_frame(12'd1200);
      run_stages(0, 5);
      tick();
      n_checks++;
      if (bus.Nf !== nf_exp || bus.Nf_PFA !== pfa_exp) begin
         n_errors++;
         $display("FAIL cfg_1200_factors: Nf %o Nf_PFA %h required %o %h", bus.Nf, bus.Nf_PFA, nf_exp, pfa_exp);
      end
      n_checks++;
      if (bus.q_p !== 10'd75 || bus.r_p !== 10'd11 || bus.q_p_o !== 10'd48 || bus.r_p_o !== 10'd23) begin
         n_errors++;
         $display("FAIL cfg_1200_pfa: %0d %0d %0d %0d required 75 11 48 23",
                  bus.q_p, bus.r_p, bus.q_p_o, bus.r_p_o);
      end
      n_checks++;
      if (n_done - d0 !== 1 || bus.frame_done !== 1'b0) begin
         n_errors++;
         $display("FAIL frame_done_count: got %0d pulses, now %b, required 1 pulse then 0",
                  n_done - d0, bus.frame_done);
      end
   endtask

   task automatic test_frame_60();
      logic [5:0][2:0] nf_exp;
      logic [2:0][9:0] pfa_exp;
      nf_exp[0] = 3'd4; nf_exp[1] = 3'd5; nf_exp[2] = 3'd3;
      nf_exp[3] = 3'd1; nf_exp[4] = 3'd1; nf_exp[5] = 3'd1;
      pfa_exp[0] = 10'd4; pfa_exp[1] = 10'd5; pfa_exp[2] = 10'd3;
      start_frame(12'd60);
      n_checks++;
      if (bus.Nf !== nf_exp || bus.Nf_PFA !== pfa_exp || bus.q_p !== 10'd15 || bus.r_p !== 10'd3 ||
          bus.q_p_o !== 10'd12 || bus.r_p_o !== 10'd2) begin
         n_errors++;
         $display("FAIL cfg_60: Nf %o Nf_PFA %h q/r %0d %0d %0d %0d required %o %h 15 3 12 2",
                  bus.Nf, bus.Nf_PFA, bus.q_p, bus.r_p, bus.q_p_o, bus.r_p_o, nf_exp, pfa_exp);
      end
      run_stages(0, 3);
      tick();
   endtask

   task automatic test_bad_size();
      int c0;
      c0 = n_cfg;
      bus.sink_sop    = 1'b1;
      bus.sink_dftpts = 12'd1000;
      tick();
      bus.sink_sop = 1'b0;
      n_checks++;
      if (bus.err_cfg !== 1'b1 || bus.state !== 2'b00 || bus.dftpts !== 12'd60 || bus.Nf_PFA[0] !== 10'd4) begin
         n_errors++;
         $display("FAIL bad_size: err_cfg %b state %b dftpts %0d N1 %0d required 1 00 60 4",
                  bus.err_cfg, bus.state, bus.dftpts, bus.Nf_PFA[0]);
      end
      tick();
      n_checks++;
      if (bus.err_cfg !== 1'b0 || bus.state !== 2'b00 || n_cfg - c0 !== 1) begin
         n_errors++;
         $display("FAIL bad_size_pulse: err_cfg %b state %b pulses %0d required 0 00 1",
                  bus.err_cfg, bus.state, n_cfg - c0);
      end
      start_frame(12'd1200);
      run_stages(0, 5);
      tick();
   endtask

   task automatic test_drop_sop();
      int d0;
      d0 = n_drop;
      start_frame(12'd1200);
      for (int s = 0; s < 2; s++) begin
         do_phase(1, 3'(s), 2'b10, 3'(s));
         do_phase(2, 3'(s), 2'b01, 3'(s + 1));
      end
      bus.rd_ongoing = 1'b1;
      tick();
      tick();
      bus.sink_sop    = 1'b1;
      bus.sink_dftpts = 12'd60;
      tick();
      bus.sink_sop = 1'b0;
      n_checks++;
      if (bus.drop_sop !== 1'b1 || bus.dftpts !== 12'd1200 || bus.current_stage !== 3'd2 || bus.state !== 2'b01) begin
         n_errors++;
         $display("FAIL drop_sop: drop %b dftpts %0d stage %0d state %b required 1 1200 2 01",
                  bus.drop_sop, bus.dftpts, bus.current_stage, bus.state);
      end
      tick();
      bus.rd_ongoing = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.state !== 2'b10 || bus.current_stage !== 3'd2 || n_drop - d0 !== 1) begin
         n_errors++;
         $display("FAIL drop_sop_after: state %b stage %0d pulses %0d required 10 2 1",
                  bus.state, bus.current_stage, n_drop - d0);
      end
      do_phase(2, 3'd2, 2'b01, 3'd3);
      run_stages(3, 5);
      tick();
   endtask

   task automatic test_timeout();
      int t0;
      int bad = 0;
      t0 = n_tmo;
      start_frame(12'd1200);
      for (int i = 0; i < 4094; i++) begin
         tick();
         if (bus.err_timeout !== 1'b0 || bus.state !== 2'b01) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL timeout_early: %0d cycles left state 01 or pulsed before 4095, required 0", bad);
      end
      tick();
      n_checks++;
      if (bus.err_timeout !== 1'b1 || bus.state !== 2'b00 || bus.current_stage !== 3'd0) begin
         n_errors++;
         $display("FAIL timeout_fire: err %b state %b stage %0d required 1 00 0",
                  bus.err_timeout, bus.state, bus.current_stage);
      end
      tick();
      n_checks++;
      if (bus.err_timeout !== 1'b0 || n_tmo - t0 !== 1) begin
         n_errors++;
         $display("FAIL timeout_pulse: err %b pulses %0d required 0 1", bus.err_timeout, n_tmo - t0);
      end
   endtask

   task automatic test_timeout_rise_wins();
      int t0;
      t0 = n_tmo;
      start_frame(12'd1200);
      for (int i = 0; i < 4093; i++) tick();
      bus.rd_ongoing = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.err_timeout !== 1'b0 || bus.state !== 2'b01) begin
         n_errors++;
         $display("FAIL rise_wins: err %b state %b required 0 01", bus.err_timeout, bus.state);
      end
      bus.rd_ongoing = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.state !== 2'b10 || bus.current_stage !== 3'd0) begin
         n_errors++;
         $display("FAIL rise_wins_run: state %b stage %0d required 10 0", bus.state, bus.current_stage);
      end
      do_phase(2, 3'd0, 2'b01, 3'd1);
      run_stages(1, 5);
      tick();
      n_checks++;
      if (n_tmo != t0) begin
         n_errors++;
         $display("FAIL rise_wins_count: %0d timeout pulses required 0", n_tmo - t0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int p0;
      p0 = n_done + n_drop + n_cfg + n_tmo;
      start_frame(12'd1200);
      for (int s = 0; s < 3; s++) begin
         do_phase(1, 3'(s), 2'b10, 3'(s));
         do_phase(2, 3'(s), 2'b01, 3'(s + 1));
      end
      do_phase(1, 3'd3, 2'b10, 3'd3);
      tick();
      bus.wr_ongoing = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      n_checks++;
      if (bus.state !== 2'b00 || bus.current_stage !== 3'd0 || bus.dftpts !== 12'd0 ||
          bus.Nf !== 18'o111111 || bus.Nf_PFA !== 30'd0 || bus.q_p !== 10'd0 || bus.r_p_o !== 10'd0) begin
         n_errors++;
         $display("FAIL reset_mid: state %b stage %0d dftpts %0d Nf %o Nf_PFA %h required 00 0 0 111111 0",
                  bus.state, bus.current_stage, bus.dftpts, bus.Nf, bus.Nf_PFA);
      end
      rst_n = 1'b1;
      bus.wr_ongoing = 1'b0;
      tick();
      n_checks++;
      if (n_done + n_drop + n_cfg + n_tmo != p0) begin
         n_errors++;
         $display("FAIL reset_mid_pulses: %0d pulses required 0", n_done + n_drop + n_cfg + n_tmo - p0);
      end
      start_frame(12'd1200);
      run_stages(0, 5);
      tick();
   endtask

   task automatic test_back_to_back();
      int d0;
      int f0;
      d0 = n_drop;
      f0 = n_done;
      start_frame(12'd1200);
      run_stages(0, 5);
      tick();
      n_checks++;
      if (bus.frame_done !== 1'b0 || bus.state !== 2'b00) begin
         n_errors++;
         $display("FAIL b2b_gap: frame_done %b state %b required 0 00", bus.frame_done, bus.state);
      end
      start_frame(12'd1200);
      run_stages(0, 5);
      tick();
      n_checks++;
      if (n_drop != d0 || n_done - f0 !== 2) begin
         n_errors++;
         $display("FAIL b2b_counts: drops %0d frames %0d required 0 2", n_drop - d0, n_done - f0);
      end
   endtask

   initial begin
      test_reset();
      test_frame_1200();
      test_frame_60();
      test_bad_size();
      test_drop_sop();
      test_timeout();
      test_timeout_rise_wins();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mrd_ctrl_seq.md
# mrd_ctrl_seq

Frame sequencer for the mixed-radix DFT memory subsystem. It drives the memory top's control interface (`state`, `current_stage`, radix factors, PFA parameters) through the phases sink → read/write per butterfly stage → source, and advances on the memory's status handshakes (`sink_ongoing`, `rd_ongoing`, `wr_ongoing`, `source_ongoing`). It latches the per-frame DFT size, selects the factorisation for it, and flags timeouts, unsupported sizes and frames dropped while busy.

## Interface
- `TIMEOUT`, default 4095 — maximum cycles to wait for an expected status rising edge.
- `W_CNT`, default 12 — watchdog counter width.
- `clk`  in  1 — clock.
- `rst_n`  in  1 — reset; one clock, synchronous, active-low.
- `sink_sop`  in  1 — input frame start (`stat_to_ctrl.sink_sop`).
- `sink_dftpts`  in  12 — frame size, valid with `sink_sop`.
- `sink_ongoing`, `rd_ongoing`, `wr_ongoing`, `source_ongoing`  in  1 each — memory status.
- `state`  out  2 — 00 sink, 01 read, 10 write, 11 source.
- `current_stage`  out  3 — butterfly stage index.
- `dftpts`  out  12 — latched frame size.
- `Nf`  out  6×3 — radix per stage; unused stages are 1.
- `Nf_PFA`  out  3×10 — PFA factors N1..N3.
- `q_p`, `r_p`, `q_p_o`, `r_p_o`  out  10 each — PFA input and output index constants.
- `frame_done`  out  1 — one-cycle pulse when source completes.
- `err_timeout`, `err_cfg`, `drop_sop`  out  1 each — one-cycle error pulses.

## Operation
- Internal FSM:
  - SINK_IDLE (`state` 00): wait for `sink_sop`.
  - SINK_RUN (00): wait for the falling edge of `sink_ongoing`.
  - RD_ARM (01): wait for `rd_ongoing` to rise.
  - RD_RUN (01): wait for `rd_ongoing` to fall.
  - WR_ARM (10): wait for `wr_ongoing` to rise.
  - WR_RUN (10): wait for `wr_ongoing` to fall.
  - SRC_ARM (11): wait for `source_ongoing` to rise.
  - SRC_RUN (11): wait for `source_ongoing` to fall.
- Edge detection uses one register stage of each status input.
- SINK_IDLE, on `sink_sop`: latch `sink_dftpts` into `dftpts`, look up the configuration, go to SINK_RUN.
  - If the size is unsupported: pulse `err_cfg`, keep outputs unchanged, stay in SINK_IDLE.
- SINK_RUN, `sink_ongoing` falls: `current_stage` ← 0, go to RD_ARM.
- RD_RUN, `rd_ongoing` falls: go to WR_ARM.
- WR_RUN, `wr_ongoing` falls:
  - If `current_stage == num_stages-1`: go to SRC_ARM.
  - Otherwise: `current_stage`+1, go to RD_ARM.
- SRC_RUN, `source_ongoing` falls: pulse `frame_done`, `current_stage` ← 0, go to SINK_IDLE.
- `sink_sop` in any state other than SINK_IDLE: pulse `drop_sop`; ignore the frame; `dftpts` is not updated.
- Watchdog: counts cycles in each *_ARM state and clears on state change.
  - On reaching `TIMEOUT`: pulse `err_timeout`, go to SINK_IDLE, `current_stage` ← 0.
  - *_RUN states have no watchdog; the memory bounds their length.
- Supported sizes live in the package table.
  - Mandatory entry 1200: `Nf` = {4,4,5,5,3,1}, `num_stages` = 5, `Nf_PFA` = {16,25,3}, `q_p`/`r_p`/`q_p_o`/`r_p_o` = package constants.
- Status edges detected in a state where they are not awaited are ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `state` 00, internal SINK_IDLE.
  - `current_stage` 0, `dftpts` 0.
  - `Nf` all 1, `Nf_PFA` 0, `q_p`/`r_p`/`q_p_o`/`r_p_o` 0.
  - All pulses 0.
- `sink_sop` at cycle t: `dftpts` and configuration are valid at t+1. The memory latches `dftpts` on `sop` itself; the configuration must be stable before the first read.
- Status falling edge in input cycle t: the registered edge is seen at t+1, and the new `state` / `current_stage` appears at t+2.
- `state` and `current_stage` change in the same cycle; the memory's `state != state_r` detect sees both.
- `current_stage` and the configuration are constant for the whole of each read and write phase.
- The watchdog times out at cycle `TIMEOUT` after ARM entry. A rising edge in the same cycle wins.
- Reset mid-frame: FSM to SINK_IDLE next edge, with no pulses.

## Structure
- Package `mrd_ctrl_pkg` holds:
  - The state enum.
  - `mrd_cfg_t` struct: `num_stages`, `Nf[6]`, `Nf_PFA[3]`, `q_p`, `r_p`, `q_p_o`, `r_p_o`, `valid`.
  - The size table constant.
- Sub-module `mrd_cfg_lut`: combinational `dftpts` → `mrd_cfg_t`, with `valid`=0 for unknown sizes.
- The top holds the FSM, edge detectors, watchdog and output registers.

## Test plan
- 1200-point frame with a memory model:
  - `state` sequence 00, 01, 10 ×5 with `current_stage` 0..4, then 11, 00.
  - `Nf` = {4,4,5,5,3,1}, `Nf_PFA` = {16,25,3}.
  - `frame_done` pulses once.
- `sink_sop` with `sink_dftpts` = 1000 → `err_cfg` pulse; `state` stays 00; the next 1200 frame runs normally.
- `sink_sop` during stage 2 read → `drop_sop` pulse; `dftpts` stays 1200; `current_stage` unaffected.
- `rd_ongoing` held 0 after entering state 01 → `err_timeout` exactly 4095 cycles after ARM entry; `state` 00; `current_stage` 0.
- `rst_n` low during stage 3 write → all outputs at reset values next cycle; a new 1200 frame completes.
- Back-to-back frames, second `sop` one cycle after `frame_done` → accepted, no `drop_sop`.
